// File: rtl/rgb_frame_reader.sv
// Reads the packed RGB frame (3 SRAM words per 2 pixels) from external SRAM and presents it as a
// valid/ready stream of 24-bit pixels with line-end and frame-last flags, buffered in a small FIFO.
module rgb_frame_reader #(
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [15:0] SRAM_write_data,
  input  logic [15:0] SRAM_read_data,
  output logic [7:0]  pixel_R,
  output logic [7:0]  pixel_G,
  output logic [7:0]  pixel_B,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic        pixel_line_end,
  output logic        pixel_last
);

  localparam int unsigned TotalWords = IMG_WIDTH * IMG_HEIGHT * 3 / 2;
  localparam logic [17:0] LastAddr   = 18'(32'(RGB_BASE) + TotalWords - 1);
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW       = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned XW         = $clog2(IMG_WIDTH);
  localparam int unsigned YW         = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

  state_e          state_q;
  logic [1:0]      trip_q;
  logic [1:0]      pipe_v_q;
  logic [1:0]      ph0_q;
  logic [1:0]      ph1_q;
  logic [7:0]      r_q;
  logic [7:0]      g_q;
  logic [CntW-1:0] in_flight_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;

  logic [25:0]     mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [CntW:0]   reserve;
  logic            room;
  logic            issue;
  logic            trip_start;
  logic            last_issue;
  logic            push;
  logic            pop;
  logic [25:0]     push_pix;
  logic [25:0]     head;
  logic            frame_end;

  // A triplet yields two pixels; only start one if the FIFO can absorb them along with
  // everything already requested.
  assign reserve    = {1'b0, count_q} + {1'b0, in_flight_q} + (CntW + 1)'(2);
  assign room       = reserve <= (CntW + 1)'(FIFO_DEPTH);
  assign issue      = (state_q == StFetch) && ((trip_q != 2'd0) || room);
  assign trip_start = issue && (trip_q == 2'd0);
  assign last_issue = issue && (trip_q == 2'd2) && (SRAM_address == LastAddr);

  assign push      = pipe_v_q[1] && (ph1_q != 2'd0);
  assign pop       = pixel_valid && pixel_ready;
  assign head      = mem[rd_ptr_q];
  assign frame_end = pop && head[0];

  assign SRAM_we_n       = 1'b1;
  assign SRAM_write_data = 16'd0;

  assign pixel_valid = count_q != '0;
  assign {pixel_R, pixel_G, pixel_B, pixel_line_end, pixel_last} = pixel_valid ? head : 26'd0;

  always_comb begin
    push_pix        = '0;
    push_pix[1]     = x_q == XW'(IMG_WIDTH - 1);
    push_pix[0]     = push_pix[1] && (y_q == YW'(IMG_HEIGHT - 1));
    if (ph1_q == 2'd1) begin
      push_pix[25:2] = {r_q, g_q, SRAM_read_data[15:8]};
    end else begin
      push_pix[25:2] = {r_q, SRAM_read_data[15:8], SRAM_read_data[7:0]};
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      busy         <= 1'b0;
      done         <= 1'b0;
      SRAM_address <= RGB_BASE;
      trip_q       <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q      <= StFetch;
            busy         <= 1'b1;
            SRAM_address <= RGB_BASE;
            trip_q       <= 2'd0;
          end
        end
        StFetch: begin
          if (issue) begin
            trip_q <= (trip_q == 2'd2) ? 2'd0 : trip_q + 2'd1;
            if (SRAM_address != LastAddr) begin
              SRAM_address <= SRAM_address + 18'd1;
            end
            if (last_issue) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (frame_end) begin
            state_q      <= StDone;
            done         <= 1'b1;
            busy         <= 1'b0;
            SRAM_address <= RGB_BASE;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read returns lag their address by two cycles; the tag pipe says which word of a triplet
  // is on the bus.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      pipe_v_q    <= 2'b00;
      ph0_q       <= 2'd0;
      ph1_q       <= 2'd0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      in_flight_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      pipe_v_q <= {pipe_v_q[0], issue};
      ph0_q    <= trip_q;
      ph1_q    <= ph0_q;

      if (pipe_v_q[1]) begin
        if (ph1_q == 2'd0) begin
          r_q <= SRAM_read_data[15:8];
          g_q <= SRAM_read_data[7:0];
        end else if (ph1_q == 2'd1) begin
          r_q <= SRAM_read_data[7:0];
        end
      end

      case ({trip_start, push})
        2'b10:   in_flight_q <= in_flight_q + CntW'(2);
        2'b01:   in_flight_q <= in_flight_q - CntW'(1);
        2'b11:   in_flight_q <= in_flight_q + CntW'(1);
        default: in_flight_q <= in_flight_q;
      endcase

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (x_q == XW'(IMG_WIDTH - 1)) begin
          x_q <= '0;
          y_q <= (y_q == YW'(IMG_HEIGHT - 1)) ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end

      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end

      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (push) begin
      mem[wr_ptr_q] <= push_pix;
    end
  end

endmodule
